pipe_hazard_ctrl: RTL

Hazard and stall controller for the filter processor's four-stage pipeline register chain (IF/ID, ID/EX, EX/MEM, MEM/WB). It produces the per-stage hold enables and the bubble/flush controls that drive those registers. It resolves three events:
- load-use hazards
- multi-cycle memory waits
- taken branches

It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag for debug.

---
 rtl/filt_pkg.sv | 15 +
 rtl/hazard_cmp.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/filt_pkg.sv
// Shared definitions for the filter processor pipeline control blocks.
// Holds the hazard FSM state encoding and common widths.
package filt_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int REG_ADDR_W      = 4;
  localparam int DATA_W          = 32;
  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int WAIT_W          = 16;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags an ID-stage source that depends on a load in EX.
// Purely combinational so the forwarding unit can reuse it.
module hazard_cmp
  import filt_pkg::*;
(
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_a_i,
  input  logic [REG_ADDR_W-1:0] id_rs_b_i,
  input  logic                  id_use_a_i,
  input  logic                  id_use_b_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_re_i,
  output logic                  hazard_o
);

  logic match_a;
  logic match_b;

  // Register 0 is a real register here, so no zero-index exemption.
  assign match_a  = id_use_a_i & (id_rs_a_i == ex_rd_i);
  assign match_b  = id_use_b_i & (id_rs_b_i == ex_rd_i);
  assign hazard_o = ex_mem_re_i & id_valid_i & (match_a | match_b);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the four pipeline registers: memory waits,
// taken-branch flushes and load-use bubbles, plus stall/timeout debug state.
module pipe_hazard_ctrl
  import filt_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_a,
  input  logic [REG_ADDR_W-1:0] id_rs_b,
  input  logic                  id_use_a,
  input  logic                  id_use_b,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_RE,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  hold_if,
  output logic                  hold_id,
  output logic                  hold_ex,
  output logic                  hold_mem,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  timeout_err
);

  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;
  logic              load_use;

  hazard_cmp u_hazard_cmp (
    .id_valid_i  (id_valid),
    .id_rs_a_i   (id_rs_a),
    .id_rs_b_i   (id_rs_b),
    .id_use_a_i  (id_use_a),
    .id_use_b_i  (id_use_b),
    .ex_rd_i     (ex_rd),
    .ex_mem_re_i (ex_mem_RE),
    .hazard_o    (load_use)
  );

  // While in reset the whole chain is frozen with a bubble staged in ID/EX.
  always_comb begin
    hold_if   = 1'b0;
    hold_id   = 1'b0;
    hold_ex   = 1'b0;
    hold_mem  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (!rst_n) begin
      hold_if   = 1'b1;
      hold_id   = 1'b1;
      hold_ex   = 1'b1;
      hold_mem  = 1'b1;
      bubble_ex = 1'b1;
    end else if (state_q == MEM_WAIT) begin
      hold_if  = ~mem_ack;
      hold_id  = ~mem_ack;
      hold_ex  = ~mem_ack;
      hold_mem = ~mem_ack;
    end else if (mem_req && !mem_ack) begin
      hold_if  = 1'b1;
      hold_id  = 1'b1;
      hold_ex  = 1'b1;
      hold_mem = 1'b1;
    end else if (ex_branch_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use) begin
      hold_if   = 1'b1;
      hold_id   = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ack) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
        // Timeout is only recorded; the FSM keeps waiting for the ack.
        if (!mem_ack && (wait_cnt_d == TIMEOUT_C)) timeout_d = 1'b1;
        if (mem_ack) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (hold_if && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign timeout_err = timeout_q;

endmodule
